// File: rtl/sd_stream_pkg.sv
// Shared types and constants for the SD sector streamer.
// State encoding, sector geometry and the words-per-sector helper.
package sd_stream_pkg;

   localparam int unsigned SD_SECTOR_BITS = 4096;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_INIT,
      ST_REQ,
      ST_WAIT_DONE,
      ST_EMIT,
      ST_ERR,
      ST_FINISH
   } state_e;

   function automatic int unsigned words_per_sector(input int unsigned word_width);
      return SD_SECTOR_BITS / word_width;
   endfunction

endpackage

// File: rtl/sd_word_select.sv
// Picks word sel from the 4096-bit sector (MSB-first) and registers it as RAM write data.
// Optional byte reversal of each word when SD_STREAM_BYTESWAP_EN is defined.
module sd_word_select
   import sd_stream_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned SEL_W      = $clog2(words_per_sector(WORD_WIDTH))
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [SEL_W-1:0]          sel,
   input  logic [SD_SECTOR_BITS-1:0] sector,
   output logic [WORD_WIDTH-1:0]     data
);

   localparam int unsigned WORDS = words_per_sector(WORD_WIDTH);

   logic [WORD_WIDTH-1:0] words [WORDS];
   logic [WORD_WIDTH-1:0] picked;

   // word 0 occupies the most significant bits (first received on the bus)
   for (genvar k = 0; k < WORDS; k++) begin : g_unpack
      assign words[k] = sector[SD_SECTOR_BITS-1-k*WORD_WIDTH -: WORD_WIDTH];
   end

`ifdef SD_STREAM_BYTESWAP_EN
   if (WORD_WIDTH % 8 != 0) begin : g_bad_width
      $error("sd_word_select: byte swap needs WORD_WIDTH to be a multiple of 8");
   end

   function automatic logic [WORD_WIDTH-1:0] byte_swap(input logic [WORD_WIDTH-1:0] w);
      logic [WORD_WIDTH-1:0] r;
      r = '0;
      for (int b = 0; b < int'(WORD_WIDTH / 8); b++) begin
         r[8*b +: 8] = w[WORD_WIDTH-8-8*b +: 8];
      end
      return r;
   endfunction

   assign picked = byte_swap(words[sel]);
`else
   assign picked = words[sel];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
      end else if (load) begin
         data <= picked;
      end
   end

endmodule

// File: rtl/sd_sector_streamer.sv
// Requests consecutive SD sectors and unpacks each into one RAM word write per clock.
// Optional byte swap of emitted words: define SD_STREAM_BYTESWAP_EN.
module sd_sector_streamer
   import sd_stream_pkg::*;
#(
   parameter int unsigned WORD_WIDTH     = 16,
   parameter int unsigned RAM_ADDR_WIDTH = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [31:0]               base_sector,
   input  logic [15:0]               sector_count,
   input  logic                      sd_has_initialized,
   input  logic                      sd_is_reading,
   input  logic [SD_SECTOR_BITS-1:0] sd_data_read,
   output logic                      sd_to_read,
   output logic [31:0]               sd_read_address,
   output logic                      wr_en,
   output logic [RAM_ADDR_WIDTH-1:0] wr_addr,
   output logic [WORD_WIDTH-1:0]     wr_data,
   output logic                      busy,
   output logic                      done,
   output logic                      error
);

   localparam int unsigned WORDS = words_per_sector(WORD_WIDTH);
   localparam int unsigned SEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned CNT_W = SEL_W + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e                    state_q, state_d;
   logic [31:0]               base_q, base_d;
   logic [15:0]               count_q, count_d;
   logic [15:0]               sec_idx_q, sec_idx_d;
   logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
   logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
   logic [31:0]               addr_d;
   logic [RAM_ADDR_WIDTH-1:0] wr_addr_d;
   logic                      busy_d, error_d, tmo_clr, tmo_hit, load;

   assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         base_q          <= '0;
         count_q         <= '0;
         sec_idx_q       <= '0;
         word_cnt_q      <= '0;
         tmo_cnt_q       <= '0;
         sd_to_read      <= 1'b0;
         sd_read_address <= '0;
         wr_en           <= 1'b0;
         wr_addr         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
      end else begin
         state_q         <= state_d;
         base_q          <= base_d;
         count_q         <= count_d;
         sec_idx_q       <= sec_idx_d;
         word_cnt_q      <= word_cnt_d;
         tmo_cnt_q       <= tmo_cnt_d;
         sd_to_read      <= (state_d == ST_REQ);
         sd_read_address <= addr_d;
         wr_en           <= load;
         wr_addr         <= wr_addr_d;
         busy            <= busy_d;
         done            <= (state_q == ST_FINISH);
         error           <= error_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      count_d   = count_q;
      sec_idx_d = sec_idx_q;
      addr_d    = sd_read_address;
      busy_d    = busy;
      error_d   = error;
      tmo_clr   = 1'b0;
      wr_addr_d = wr_en ? wr_addr + RAM_ADDR_WIDTH'(1) : wr_addr;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d    = base_sector;
               count_d   = sector_count;
               sec_idx_d = '0;
               error_d   = 1'b0;
               busy_d    = 1'b1;
               wr_addr_d = '0;
               state_d   = (sector_count == 16'd0) ? ST_FINISH : ST_WAIT_INIT;
            end
         end
         ST_WAIT_INIT: begin
            if (sd_has_initialized) begin
               state_d = ST_REQ;
               addr_d  = base_q + 32'(sec_idx_q);
               tmo_clr = 1'b1;
            end
         end
         ST_REQ: begin
            if (sd_is_reading) begin
               state_d = ST_WAIT_DONE;
               tmo_clr = 1'b1;
            end else if (tmo_hit) begin
               state_d = ST_ERR;
            end
         end
         ST_WAIT_DONE: begin
            if (!sd_is_reading) begin
               state_d = ST_EMIT;
            end else if (tmo_hit) begin
               state_d = ST_ERR;
            end
         end
         ST_EMIT: begin
            // word_cnt counts words already issued; all WORDS out means sector complete
            if (word_cnt_q == CNT_W'(WORDS)) begin
               sec_idx_d = sec_idx_q + 16'd1;
               if (sec_idx_d == count_q) begin
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_REQ;
                  addr_d  = base_q + 32'(sec_idx_d);
                  tmo_clr = 1'b1;
               end
            end
         end
         ST_ERR: begin
            error_d = 1'b1;
            state_d = ST_FINISH;
         end
         ST_FINISH: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      load       = (state_d == ST_EMIT);
      word_cnt_d = load ? word_cnt_q + CNT_W'(1) : '0;

      if (tmo_clr) begin
         tmo_cnt_d = '0;
      end else if (state_q == ST_REQ || state_q == ST_WAIT_DONE) begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end else begin
         tmo_cnt_d = tmo_cnt_q;
      end
   end

   sd_word_select #(
      .WORD_WIDTH (WORD_WIDTH),
      .SEL_W      (SEL_W)
   ) u_word_select (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .sel    (word_cnt_q[SEL_W-1:0]),
      .sector (sd_data_read),
      .data   (wr_data)
   );

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Directed bench for sd_sector_streamer with a behavioural SD controller and write scoreboard.
module tb_sd_sector_streamer;

   localparam int unsigned WW = 16;
   localparam int unsigned AW = 9;
   localparam int unsigned TO = 100;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [31:0]     base_sector;
   logic [15:0]     sector_count;
   logic            sd_has_initialized;
   logic            sd_is_reading;
   logic [4095:0]   sd_data_read;
   logic            sd_to_read;
   logic [31:0]     sd_read_address;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [WW-1:0]   wr_data;
   logic            busy;
   logic            done;
   logic            error;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int req_rise_cyc = 0;
   bit sd_respond = 1'b1;
   bit prev_to_read = 1'b0;

   int          exp_wa[$];
   logic [15:0] exp_wd[$];
   logic [31:0] exp_sd[$];

   sd_sector_streamer #(
      .WORD_WIDTH     (WW),
      .RAM_ADDR_WIDTH (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .base_sector        (base_sector),
      .sector_count       (sector_count),
      .sd_has_initialized (sd_has_initialized),
      .sd_is_reading      (sd_is_reading),
      .sd_data_read       (sd_data_read),
      .sd_to_read         (sd_to_read),
      .sd_read_address    (sd_read_address),
      .wr_en              (wr_en),
      .wr_addr            (wr_addr),
      .wr_data            (wr_data),
      .busy               (busy),
      .done               (done),
      .error              (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_word(input logic [31:0] a, input int k);
      logic [15:0] w;
      w = {a[7:0], 8'(k)};
`ifdef SD_STREAM_BYTESWAP_EN
      w = {w[7:0], w[15:8]};
`endif
      return w;
   endfunction

   // SD controller model: answers each request once, sector word k = {addr[7:0], k}
   initial begin : sd_model
      sd_is_reading = 1'b0;
      sd_data_read  = '0;
      forever begin
         @(posedge clk); #1;
         if (sd_to_read && sd_respond) begin
            repeat (2) @(posedge clk);
            #1;
            for (int k = 0; k < 256; k++) begin
               sd_data_read[4095-16*k -: 16] = {sd_read_address[7:0], 8'(k)};
            end
            sd_is_reading = 1'b1;
            repeat (3) @(posedge clk);
            #1 sd_is_reading = 1'b0;
         end
      end
   end

   // output monitor: pops scoreboard on each write and each new SD request
   always @(negedge clk) begin
      if (sd_to_read && !prev_to_read) begin
         req_rise_cyc = cyc;
         chk("sd_req_expected", 32'(exp_sd.size() > 0), 32'd1);
         if (exp_sd.size() > 0) chk("sd_read_address", sd_read_address, exp_sd.pop_front());
      end
      prev_to_read = sd_to_read;
      if (wr_en) begin
         chk("wr_expected", 32'(exp_wa.size() > 0), 32'd1);
         if (exp_wa.size() > 0) begin
            chk("wr_addr", 32'(wr_addr), 32'(exp_wa.pop_front()));
            chk("wr_data", 32'(wr_data), 32'(exp_wd.pop_front()));
         end
      end
   end

   task automatic push_xfer(input logic [31:0] base, input int count);
      int wa;
      wa = 0;
      for (int s = 0; s < count; s++) begin
         exp_sd.push_back(base + 32'(s));
         for (int k = 0; k < 256; k++) begin
            exp_wa.push_back(wa % (1 << AW));
            exp_wd.push_back(exp_word(base + 32'(s), k));
            wa++;
         end
      end
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [15:0] count);
      @(posedge clk); #1;
      base_sector  = base;
      sector_count = count;
      start        = 1'b1;
      @(posedge clk); #1;
      start        = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_within_budget", 32'(done), 32'd1);
   endtask

   task automatic check_clean_done(input string tag, input logic exp_err);
      chk({tag, "_error"}, 32'(error), 32'(exp_err));
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      chk({tag, "_wr_left"}, 32'(exp_wa.size()), 32'd0);
      chk({tag, "_sd_left"}, 32'(exp_sd.size()), 32'd0);
   endtask

   initial begin : main
      bit seen;
      int lat;
      rst_n = 1'b0;
      start = 1'b0;
      base_sector = '0;
      sector_count = '0;
      sd_has_initialized = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sd_to_read", 32'(sd_to_read), 32'd0);
      chk("rst_sd_read_address", sd_read_address, 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      rst_n = 1'b1;

      // single sector
      push_xfer(32'h100, 1);
      pulse_start(32'h100, 16'd1);
      chk("single_busy", 32'(busy), 32'd1);
      wait_done(2000);
      check_clean_done("single", 1'b0);

      // three sectors, WR_ADDR wraps at 512
      push_xfer(32'h100, 3);
      pulse_start(32'h100, 16'd3);
      wait_done(5000);
      check_clean_done("multi", 1'b0);

      // zero count: DONE two cycles after START, no SD access
      pulse_start(32'h300, 16'd0);
      @(negedge clk);
      chk("zero_done_early", 32'(done), 32'd0);
      chk("zero_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("zero_done", 32'(done), 32'd1);
      check_clean_done("zero", 1'b0);

      // init gating
      sd_has_initialized = 1'b0;
      push_xfer(32'h1AB, 1);
      pulse_start(32'h1AB, 16'd1);
      seen = 1'b0;
      repeat (500) begin
         @(negedge clk);
         seen |= sd_to_read;
      end
      chk("init_gate_no_req", 32'(seen), 32'd0);
      chk("init_gate_busy", 32'(busy), 32'd1);
      sd_has_initialized = 1'b1;
      wait_done(2000);
      check_clean_done("init_gate", 1'b0);

      // timeout: controller never answers
      sd_respond = 1'b0;
      exp_sd.push_back(32'h200);
      pulse_start(32'h200, 16'd1);
      wait_done(1000);
      lat = cyc - req_rise_cyc;
      chk("tmo_latency_window", 32'(lat >= 99 && lat <= 105), 32'd1);
      chk("tmo_to_read_low", 32'(sd_to_read), 32'd0);
      check_clean_done("tmo", 1'b1);
      sd_respond = 1'b1;
      pulse_start(32'h0, 16'd0);
      chk("tmo_error_cleared", 32'(error), 32'd0);
      wait_done(20);

      // reset in the middle of EMIT, at word 40
      push_xfer(32'h100, 1);
      pulse_start(32'h100, 16'd1);
      seen = 1'b0;
      for (int n = 0; n < 2000 && !seen; n++) begin
         @(posedge clk); #2;
         seen = wr_en && (wr_addr == AW'(40));
      end
      chk("reached_word_40", 32'(seen), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sd_to_read", 32'(sd_to_read), 32'd0);
      chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
      chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_addr", sd_read_address, 32'd0);
      exp_wa.delete();
      exp_wd.delete();
      exp_sd.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_xfer(32'h112, 1);
      pulse_start(32'h112, 16'd1);
      wait_done(2000);
      check_clean_done("after_rst", 1'b0);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
